local_inj_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the tile's single local NoC injection port (the switch's local-in AXI-Stream) between two requesters: the accelerator output stream (port 0) and a control-path packet generator (port 1). It sits between those sources and the local-in port of `tile_noc`, on the `clk_line` domain. A grant is held from the first beat of a packet through its TLAST beat, so packets are never interleaved.

---
 rtl/local_inj_arbiter.sv | 135 +++++++++++++
 tb/tb_local_inj_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/local_inj_arbiter.sv
// Packet-level round-robin arbiter sharing the tile's local NoC injection port between two streams.
// Optional per-port packet counters are enabled by defining LOCAL_ARB_STATS_EN.
module local_inj_arbiter #(
   parameter int unsigned BW        = 32,
   parameter int unsigned BWB       = BW / 8,
   parameter int unsigned MAX_BEATS = 256
) (
   input  logic           clk_line,
   input  logic           clk_line_rst_high,

   input  logic           s0_TVALID,
   input  logic [BW-1:0]  s0_TDATA,
   input  logic [BWB-1:0] s0_TKEEP,
   input  logic           s0_TLAST,
   output logic           s0_TREADY,

   input  logic           s1_TVALID,
   input  logic [BW-1:0]  s1_TDATA,
   input  logic [BWB-1:0] s1_TKEEP,
   input  logic           s1_TLAST,
   output logic           s1_TREADY,

   output logic           m_TVALID,
   output logic [BW-1:0]  m_TDATA,
   output logic [BWB-1:0] m_TKEEP,
   output logic           m_TLAST,
   input  logic           m_TREADY,

   output logic [1:0]     grant,
   output logic           err_long_pkt,
   output logic [31:0]    pkt_cnt0,
   output logic [31:0]    pkt_cnt1
);

   localparam int unsigned CW = $clog2(MAX_BEATS) + 1;
   localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS);
   localparam logic [CW-1:0] CNT_ERR = CW'(MAX_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_t;

   state_t          state, state_nxt;
   logic            last_q;
   logic [CW-1:0]   beat_cnt;
   logic            beat;
   logic            last_beat;

   assign beat      = m_TVALID & m_TREADY;
   assign last_beat = beat & m_TLAST;
   assign grant     = {state == OWN1, state == OWN0};

   always_comb begin
      state_nxt = state;
      m_TVALID  = 1'b0;
      m_TLAST   = 1'b0;
      m_TDATA   = s0_TDATA;
      m_TKEEP   = s0_TKEEP;
      s0_TREADY = 1'b0;
      s1_TREADY = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the requester not served last wins.
            if (s0_TVALID && s1_TVALID)
               state_nxt = last_q ? OWN0 : OWN1;
            else if (s0_TVALID)
               state_nxt = OWN0;
            else if (s1_TVALID)
               state_nxt = OWN1;
         end
         OWN0: begin
            m_TVALID  = s0_TVALID;
            m_TLAST   = s0_TLAST;
            s0_TREADY = m_TREADY;
            if (s0_TVALID && m_TREADY && s0_TLAST)
               state_nxt = IDLE;
         end
         OWN1: begin
            m_TVALID  = s1_TVALID;
            m_TLAST   = s1_TLAST;
            m_TDATA   = s1_TDATA;
            m_TKEEP   = s1_TKEEP;
            s1_TREADY = m_TREADY;
            if (s1_TVALID && m_TREADY && s1_TLAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_line) begin
      if (clk_line_rst_high) begin
         state        <= IDLE;
         last_q       <= 1'b1;
         beat_cnt     <= '0;
         err_long_pkt <= 1'b0;
      end else begin
         state <= state_nxt;
         if (last_beat)
            last_q <= (state == OWN1);
         // Counter parks at MAX_BEATS so an overlong packet cannot wrap it.
         if (state == IDLE || last_beat)
            beat_cnt <= '0;
         else if (beat && beat_cnt != CNT_SAT)
            beat_cnt <= beat_cnt + 1'b1;
         if (beat && !m_TLAST && beat_cnt == CNT_ERR)
            err_long_pkt <= 1'b1;
      end
   end

`ifdef LOCAL_ARB_STATS_EN
   logic [31:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk_line) begin
      if (clk_line_rst_high) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (last_beat) begin
         if (state == OWN0 && cnt0_q != '1)
            cnt0_q <= cnt0_q + 32'd1;
         if (state == OWN1 && cnt1_q != '1)
            cnt1_q <= cnt1_q + 32'd1;
      end
   end

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
`else
   assign pkt_cnt0 = '0;
   assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_local_inj_arbiter.sv
// Directed bench for local_inj_arbiter (MAX_BEATS=8); counter expectations follow LOCAL_ARB_STATS_EN.
module tb_local_inj_arbiter;

`ifdef LOCAL_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk_line = 1'b0;
   logic        clk_line_rst_high;
   logic        s0_TVALID, s0_TLAST, s0_TREADY;
   logic [31:0] s0_TDATA;
   logic [3:0]  s0_TKEEP;
   logic        s1_TVALID, s1_TLAST, s1_TREADY;
   logic [31:0] s1_TDATA;
   logic [3:0]  s1_TKEEP;
   logic        m_TVALID, m_TLAST, m_TREADY;
   logic [31:0] m_TDATA;
   logic [3:0]  m_TKEEP;
   logic [1:0]  grant;
   logic        err_long_pkt;
   logic [31:0] pkt_cnt0, pkt_cnt1;

   int checks = 0;
   int errors = 0;

   // Source models: packets remaining, packet length, current beat, packet number.
   int s0_left, s0_len, s0_beat, s0_pkt;
   int s1_left, s1_len, s1_beat, s1_pkt;
   bit h0, h1;
   int k;
   logic [1:0] eg;

   assign s0_TVALID = (s0_left != 0);
   assign s0_TDATA  = 32'hA000_0000 | 32'(s0_pkt << 8) | 32'(s0_beat);
   assign s0_TLAST  = (s0_beat == s0_len - 1);
   assign s0_TKEEP  = 4'hF;
   assign s1_TVALID = (s1_left != 0);
   assign s1_TDATA  = 32'hB000_0000 | 32'(s1_pkt << 8) | 32'(s1_beat);
   assign s1_TLAST  = (s1_beat == s1_len - 1);
   assign s1_TKEEP  = 4'h3;

   always #5 clk_line = ~clk_line;

   local_inj_arbiter #(.BW(32), .BWB(4), .MAX_BEATS(8)) dut (
      .clk_line          (clk_line),
      .clk_line_rst_high (clk_line_rst_high),
      .s0_TVALID (s0_TVALID), .s0_TDATA (s0_TDATA), .s0_TKEEP (s0_TKEEP),
      .s0_TLAST  (s0_TLAST),  .s0_TREADY (s0_TREADY),
      .s1_TVALID (s1_TVALID), .s1_TDATA (s1_TDATA), .s1_TKEEP (s1_TKEEP),
      .s1_TLAST  (s1_TLAST),  .s1_TREADY (s1_TREADY),
      .m_TVALID  (m_TVALID),  .m_TDATA  (m_TDATA),  .m_TKEEP  (m_TKEEP),
      .m_TLAST   (m_TLAST),   .m_TREADY (m_TREADY),
      .grant        (grant),
      .err_long_pkt (err_long_pkt),
      .pkt_cnt0     (pkt_cnt0),
      .pkt_cnt1     (pkt_cnt1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Capture handshakes mid-cycle, advance to just after the next edge, then move sources on.
   task automatic step();
      h0 = s0_TVALID && s0_TREADY;
      h1 = s1_TVALID && s1_TREADY;
      @(posedge clk_line); #1;
      if (h0) begin
         if (s0_beat == s0_len - 1) begin s0_beat = 0; s0_pkt++; s0_left--; end
         else s0_beat++;
      end
      if (h1) begin
         if (s1_beat == s1_len - 1) begin s1_beat = 0; s1_pkt++; s1_left--; end
         else s1_beat++;
      end
   endtask

   task automatic do_reset();
      clk_line_rst_high = 1'b1;
      m_TREADY = 1'b1;
      s0_left = 0; s0_len = 1; s0_beat = 0; s0_pkt = 0;
      s1_left = 0; s1_len = 1; s1_beat = 0; s1_pkt = 0;
      @(posedge clk_line); #1;
      @(posedge clk_line); #1;
      clk_line_rst_high = 1'b0;
   endtask

   initial begin
      do_reset();

      // Reset state
      #4;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_mvalid", 32'(m_TVALID), 32'd0);
      check("rst_s0ready", 32'(s0_TREADY), 32'd0);
      check("rst_s1ready", 32'(s1_TREADY), 32'd0);
      check("rst_err", 32'(err_long_pkt), 32'd0);
      check("rst_cnt0", pkt_cnt0, 32'd0);
      check("rst_cnt1", pkt_cnt1, 32'd0);
      step();

      // Single requester, 4 beats
      s0_left = 1; s0_len = 4;
      for (int c = 0; c <= 5; c++) begin
         #4;
         eg = (c >= 1 && c <= 4) ? 2'b01 : 2'b00;
         check("single_grant", 32'(grant), 32'(eg));
         if (c == 0) check("single_idle_ready", 32'(s0_TREADY), 32'd0);
         if (c >= 1 && c <= 4) begin
            check("single_mvalid", 32'(m_TVALID), 32'd1);
            check("single_data", m_TDATA, 32'hA000_0000 | 32'(c - 1));
            check("single_last", 32'(m_TLAST), 32'(c == 4));
            check("single_s1ready", 32'(s1_TREADY), 32'd0);
         end
         if (c == 5) check("single_cnt0", pkt_cnt0, 32'(STATS));
         step();
      end

      // Tie after reset: port 0 first, one idle cycle, then port 1
      do_reset();
      s0_left = 1; s0_len = 3; s1_left = 1; s1_len = 3;
      for (int c = 0; c <= 8; c++) begin
         #4;
         eg = (c >= 1 && c <= 3) ? 2'b01 : (c >= 5 && c <= 7) ? 2'b10 : 2'b00;
         check("tie_grant", 32'(grant), 32'(eg));
         if (c >= 1 && c <= 3) check("tie_data0", m_TDATA, 32'hA000_0000 | 32'(c - 1));
         if (c >= 5 && c <= 7) check("tie_data1", m_TDATA, 32'hB000_0000 | 32'(c - 5));
         if (c == 4) check("tie_gap_mvalid", 32'(m_TVALID), 32'd0);
         step();
      end

      // Fairness: 10 two-beat packets alternate 0,1,0,1 with an idle cycle between
      do_reset();
      s0_left = 5; s0_len = 2; s1_left = 5; s1_len = 2;
      for (int c = 0; c <= 30; c++) begin
         #4;
         eg = (c % 3 == 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
         check("fair_grant", 32'(grant), 32'(eg));
         if (c == 30) begin
            check("fair_cnt0", pkt_cnt0, 32'(5 * STATS));
            check("fair_cnt1", pkt_cnt1, 32'(5 * STATS));
         end
         step();
      end

      // Backpressure on a 5-beat port 1 packet
      do_reset();
      s1_left = 1; s1_len = 5; k = 0;
      for (int c = 0; c <= 10; c++) begin
         m_TREADY = (c % 2 == 1);
         #4;
         eg = (c >= 1 && c <= 9) ? 2'b10 : 2'b00;
         check("bp_grant", 32'(grant), 32'(eg));
         if (c >= 1 && c <= 9) begin
            check("bp_s1ready", 32'(s1_TREADY), 32'(m_TREADY));
            check("bp_s0ready", 32'(s0_TREADY), 32'd0);
         end
         if (c == 1) check("bp_keep", 32'(m_TKEEP), 32'h3);
         if (m_TVALID && m_TREADY) begin
            check("bp_data", m_TDATA, 32'hB000_0000 | 32'(k));
            check("bp_last", 32'(m_TLAST), 32'(k == 4));
            k++;
         end
         step();
      end
      check("bp_beats", 32'(k), 32'd5);
      m_TREADY = 1'b1;

      // Long packet: 10 beats with MAX_BEATS=8
      do_reset();
      s0_left = 1; s0_len = 10; k = 0;
      for (int c = 0; c <= 11; c++) begin
         #4;
         eg = (c >= 1 && c <= 10) ? 2'b01 : 2'b00;
         check("long_grant", 32'(grant), 32'(eg));
         check("long_err", 32'(err_long_pkt), 32'(c >= 9));
         if (m_TVALID && m_TREADY) begin
            check("long_data", m_TDATA, 32'hA000_0000 | 32'(k));
            k++;
         end
         step();
      end
      check("long_beats", 32'(k), 32'd10);

      // Mid-packet reset (last is 0 here, err is 1)
      s0_left = 1; s0_len = 4; s0_beat = 0;
      #4; check("mr_idle_grant", 32'(grant), 32'd0); step();
      #4; check("mr_own_grant", 32'(grant), 32'd1); step();
      clk_line_rst_high = 1'b1;
      #4;
      check("mr_pre_err", 32'(err_long_pkt), 32'd1);
      check("mr_pre_data", m_TDATA, 32'hA000_0101);
      step();
      clk_line_rst_high = 1'b0;
      s0_left = 1; s0_beat = 0; s1_left = 1; s1_len = 3;
      #4;
      check("mr_grant", 32'(grant), 32'd0);
      check("mr_mvalid", 32'(m_TVALID), 32'd0);
      check("mr_s0ready", 32'(s0_TREADY), 32'd0);
      check("mr_s1ready", 32'(s1_TREADY), 32'd0);
      check("mr_err", 32'(err_long_pkt), 32'd0);
      check("mr_cnt0", pkt_cnt0, 32'd0);
      step();
      #4;
      check("mr_tie_last", 32'(grant), 32'd1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
